// File: rtl/periph_clk_gate_seq.sv
// rtl/periph_clk_gate_seq.sv - one-channel-at-a-time peripheral clock-gate sequencer
//
// Purpose: follows the requested clock-gate vector and applies changes to the
// clock-gate cell enables one channel at a time. Before a channel is gated,
// its peripheral is asked to quiesce. The sequencer then waits for that
// channel's idle flag or for a timeout. After a channel is ungated, the
// sequencer holds off for a fixed wake window.
//
// Ports:
//   HCLK              system clock
//   HRESETn           synchronous active-low reset
//   clk_gate_req_i    requested clock enables (1 = clock on)
//   periph_idle_i     peripheral idle flags, only sampled for the channel in service
//   clk_en_o          enables to the clock-gate cells
//   periph_stop_req_o quiesce request, one-hot or zero
//   busy_o            high while a channel is being serviced
//   timeout_evt_o     single-cycle pulse when a gating attempt gives up
//   timeout_idx_o     channel of the most recent timeout, held

module periph_clk_gate_seq #(
    parameter int N_PERIPH     = 32,
    parameter int IDLE_TIMEOUT = 64,
    parameter int WAKE_CYCLES  = 4
) (
    input  logic                        HCLK,
    input  logic                        HRESETn,
    input  logic [N_PERIPH-1:0]         clk_gate_req_i,
    input  logic [N_PERIPH-1:0]         periph_idle_i,
    output logic [N_PERIPH-1:0]         clk_en_o,
    output logic [N_PERIPH-1:0]         periph_stop_req_o,
    output logic                        busy_o,
    output logic                        timeout_evt_o,
    output logic [$clog2(N_PERIPH)-1:0] timeout_idx_o
);

    localparam int IW   = $clog2(N_PERIPH);
    localparam int TMAX = (IDLE_TIMEOUT > WAKE_CYCLES) ? IDLE_TIMEOUT : WAKE_CYCLES;
    localparam int TW   = $clog2(TMAX) + 1;

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        STOP_WAIT = 2'd1,
        WAKE      = 2'd2
    } state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [TW-1:0] timer;
    logic [IW-1:0] idx_next;
    logic          req_bit;
    logic          en_bit;
    logic          idle_bit;

    // The pointer wraps explicitly, so N_PERIPH does not have to be a power of two.
    assign idx_next = (idx == IW'(N_PERIPH - 1)) ? '0 : idx + IW'(1);
    assign req_bit  = clk_gate_req_i[idx];
    assign en_bit   = clk_en_o[idx];
    assign idle_bit = periph_idle_i[idx];

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state             <= SCAN;
            idx               <= '0;
            timer             <= '0;
            clk_en_o          <= '1;
            periph_stop_req_o <= '0;
            busy_o            <= 1'b0;
            timeout_evt_o     <= 1'b0;
            timeout_idx_o     <= '0;
        end else begin
            timeout_evt_o <= 1'b0;
            case (state)
                SCAN: begin
                    if (req_bit == en_bit) begin
                        idx <= idx_next;
                    end else if (!req_bit) begin
                        periph_stop_req_o[idx] <= 1'b1;
                        timer                  <= TW'(IDLE_TIMEOUT - 1);
                        busy_o                 <= 1'b1;
                        state                  <= STOP_WAIT;
                    end else begin
                        clk_en_o[idx] <= 1'b1;
                        timer         <= TW'(WAKE_CYCLES - 1);
                        busy_o        <= 1'b1;
                        state         <= WAKE;
                    end
                end
                STOP_WAIT: begin
                    // A request to re-enable the clock wins over idle, and idle
                    // wins over the timer. An abort therefore never reports a timeout.
                    if (req_bit) begin
                        periph_stop_req_o <= '0;
                        idx               <= idx_next;
                        busy_o            <= 1'b0;
                        state             <= SCAN;
                    end else if (idle_bit) begin
                        clk_en_o[idx]     <= 1'b0;
                        periph_stop_req_o <= '0;
                        idx               <= idx_next;
                        busy_o            <= 1'b0;
                        state             <= SCAN;
                    end else if (timer == '0) begin
                        // The clock is left running. The channel is retried on the next lap.
                        periph_stop_req_o <= '0;
                        timeout_evt_o     <= 1'b1;
                        timeout_idx_o     <= idx;
                        idx               <= idx_next;
                        busy_o            <= 1'b0;
                        state             <= SCAN;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                WAKE: begin
                    if (timer == '0) begin
                        idx    <= idx_next;
                        busy_o <= 1'b0;
                        state  <= SCAN;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                default: begin
                    periph_stop_req_o <= '0;
                    busy_o            <= 1'b0;
                    state             <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_periph_clk_gate_seq.sv
// tb/tb_periph_clk_gate_seq.sv - directed self-checking bench for periph_clk_gate_seq

module tb_periph_clk_gate_seq;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] req;
    logic [31:0] idle;
    logic [31:0] en;
    logic [31:0] stop;
    logic        busy;
    logic        evt;
    logic [4:0]  tidx;

    int checks = 0;
    int errors = 0;

    periph_clk_gate_seq #(
        .N_PERIPH     (32),
        .IDLE_TIMEOUT (8),
        .WAKE_CYCLES  (4)
    ) dut (
        .HCLK              (HCLK),
        .HRESETn           (HRESETn),
        .clk_gate_req_i    (req),
        .periph_idle_i     (idle),
        .clk_en_o          (en),
        .periph_stop_req_o (stop),
        .busy_o            (busy),
        .timeout_evt_o     (evt),
        .timeout_idx_o     (tidx)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // which: 0 = stop_req nonzero, 1 = busy high, 2 = timeout pulse
    task automatic wait_for(input string tag, input int which, input int bound);
        logic hit;
        int   n;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < bound) begin
            case (which)
                0:       hit = (stop !== 32'h0);
                1:       hit = (busy === 1'b1);
                default: hit = (evt === 1'b1);
            endcase
            if (!hit) begin
                @(negedge HCLK);
                n++;
            end
        end
        check(tag, {31'h0, hit}, 32'h1);
    endtask

    initial begin
        int cnt;

        // 1. Reset
        HRESETn = 1'b0;
        req     = 32'h0;
        idle    = 32'h0;
        @(negedge HCLK);
        @(negedge HCLK);
        check("rst_en", en, 32'hFFFF_FFFF);
        check("rst_stop", stop, 32'h0);
        check("rst_busy", {31'h0, busy}, 32'h0);
        check("rst_evt", {31'h0, evt}, 32'h0);
        check("rst_tidx", {27'h0, tidx}, 32'h0);
        req     = 32'hFFFF_FFFF;
        HRESETn = 1'b1;
        cnt     = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge HCLK);
            if (busy !== 1'b0) cnt++;
        end
        check("quiet_busy_cycles", cnt, 0);

        // 2. Gate ch3, idle immediately
        req  = ~32'h8;
        idle = 32'h8;
        wait_for("wait_gate3", 0, 40);
        check("gate3_stop", stop, 32'h8);
        @(negedge HCLK);
        check("gate3_stop_drop", stop, 32'h0);
        check("gate3_en", en, 32'hFFFF_FFF7);
        check("gate3_evt", {31'h0, evt}, 32'h0);

        // 3. Timeout on ch5
        req  = ~32'h28;
        idle = 32'h0;
        wait_for("wait_to5", 0, 40);
        check("to5_stop", stop, 32'h20);
        cnt = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge HCLK);
            if (stop === 32'h0) break;
            cnt++;
        end
        check("to5_stop_cycles", cnt, 8);
        check("to5_evt", {31'h0, evt}, 32'h1);
        check("to5_tidx", {27'h0, tidx}, 32'd5);
        check("to5_en", en, 32'hFFFF_FFF7);
        @(negedge HCLK);
        check("to5_evt_pulse", {31'h0, evt}, 32'h0);
        wait_for("wait_retry5", 0, 40);
        check("retry5_stop", stop, 32'h20);
        wait_for("wait_retry5_evt", 2, 12);
        check("retry5_tidx", {27'h0, tidx}, 32'd5);
        req = ~32'h8;

        // 4. Abort on ch7 during the 3rd cycle of STOP_WAIT
        req = ~32'h88;
        wait_for("wait_ab7", 0, 40);
        check("ab7_stop", stop, 32'h80);
        @(negedge HCLK);
        @(negedge HCLK);
        req = ~32'h8;
        @(negedge HCLK);
        check("ab7_stop_drop", stop, 32'h0);
        check("ab7_en", en, 32'hFFFF_FFF7);
        check("ab7_evt", {31'h0, evt}, 32'h0);
        check("ab7_busy", {31'h0, busy}, 32'h0);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge HCLK);
            if (evt !== 1'b0) cnt++;
        end
        check("ab7_no_evt", cnt, 0);

        // 5. Wake ch2, ch9 pending behind it
        req  = ~32'h0C;
        idle = 32'h4;
        wait_for("wait_gate2", 0, 40);
        check("gate2_stop", stop, 32'h4);
        @(negedge HCLK);
        check("gate2_en", en, 32'hFFFF_FFF3);
        req  = ~32'h08;
        idle = 32'h0;
        wait_for("wait_wake2", 1, 40);
        check("wake2_en", en, 32'hFFFF_FFF7);
        req  = ~32'h208;
        idle = 32'h200;
        cnt  = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge HCLK);
            if (busy !== 1'b1) break;
            cnt++;
            check("wake2_no_stop", stop, 32'h0);
        end
        check("wake2_busy_cycles", cnt, 4);
        check("wake2_end_stop", stop, 32'h0);
        wait_for("wait_gate9", 0, 20);
        check("gate9_stop", stop, 32'h200);
        @(negedge HCLK);
        check("gate9_en", en, 32'hFFFF_FDF7);

        // 6. Wrap ch31 -> ch0, then reset during ch0 STOP_WAIT
        req  = ~32'h8000_0209;
        idle = 32'h8000_0000;
        wait_for("wait_gate31", 0, 40);
        check("gate31_stop", stop, 32'h8000_0000);
        @(negedge HCLK);
        check("gate31_en", en, 32'h7FFF_FDF7);
        wait_for("wait_gate0", 0, 10);
        check("gate0_stop", stop, 32'h1);
        HRESETn = 1'b0;
        @(negedge HCLK);
        check("mid_rst_stop", stop, 32'h0);
        check("mid_rst_en", en, 32'hFFFF_FFFF);
        check("mid_rst_busy", {31'h0, busy}, 32'h0);
        check("mid_rst_evt", {31'h0, evt}, 32'h0);
        check("mid_rst_tidx", {27'h0, tidx}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
